// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM encodings, parity codes and the parity helper.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        UTX_IDLE,
        UTX_START,
        UTX_DATA,
        UTX_PAR,
        UTX_STOP
    } utx_state_e;

    localparam int unsigned PAR_NONE  = 0;
    localparam int unsigned PAR_EVEN  = 1;
    localparam int unsigned PAR_ODD   = 2;
    localparam int unsigned DATA_BITS = 8;

    function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..div and flags the last cycle of each bit period.
module uart_baud_cnt #(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 restart,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt_q;

    assign tick = (cnt_q == div);

    always_ff @(posedge clk) begin
        if (!reset || restart || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with a single-entry holding register so consecutive frames run gap-free.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 16,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned PARITY    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 wr_en,
    input  logic [7:0]           wr_data,
    input  logic                 clr_ovr,
    output logic                 ready,
    output logic                 busy,
    output logic                 tx_done,
    output logic                 overrun,
    output logic                 TxD
);

    utx_state_e           state_q;
    logic [7:0]           hold_q;
    logic                 hold_full_q;
    logic                 hold_full_d;
    logic [7:0]           shift_q;
    logic                 par_q;
    logic [2:0]           bit_cnt_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic                 txd_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 ovr_q;
    logic                 ready_q;

    logic tick;
    logic last_stop;
    logic frame_end;
    logic load;
    logic accept;

    assign ready   = ready_q;
    assign busy    = busy_q;
    assign tx_done = done_q;
    assign overrun = ovr_q;
    assign TxD     = txd_q;

    uart_baud_cnt #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_baud_cnt (
        .clk    (clk),
        .reset  (reset),
        .restart(load),
        .div    (div_q),
        .tick   (tick)
    );

    always_comb begin
        last_stop = (bit_cnt_q == 3'(STOP_BITS - 1));
        frame_end = (state_q == UTX_STOP) && tick && last_stop;
        // A pending byte starts either from idle or straight out of the last stop bit.
        load      = hold_full_q && ((state_q == UTX_IDLE) || frame_end);
        accept    = wr_en && !hold_full_q;
        hold_full_d = hold_full_q;
        if (load) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= UTX_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            bit_cnt_q   <= '0;
            div_q       <= '0;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovr_q       <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            hold_full_q <= hold_full_d;
            ready_q     <= !hold_full_d;
            done_q      <= frame_end;
            if (accept) begin
                hold_q <= wr_data;
            end
            if (wr_en && hold_full_q) begin
                ovr_q <= 1'b1;
            end else if (clr_ovr) begin
                ovr_q <= 1'b0;
            end

            if (load) begin
                state_q   <= UTX_START;
                shift_q   <= hold_q;
                par_q     <= parity_bit(hold_q, PARITY);
                div_q     <= baud_div;
                bit_cnt_q <= '0;
                txd_q     <= 1'b0;
                busy_q    <= 1'b1;
            end else if (tick) begin
                unique case (state_q)
                    UTX_START: begin
                        state_q   <= UTX_DATA;
                        txd_q     <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= '0;
                    end
                    UTX_DATA: begin
                        if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                            bit_cnt_q <= '0;
                            if (PARITY != PAR_NONE) begin
                                state_q <= UTX_PAR;
                                txd_q   <= par_q;
                            end else begin
                                state_q <= UTX_STOP;
                                txd_q   <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            txd_q     <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end
                    UTX_PAR: begin
                        state_q   <= UTX_STOP;
                        txd_q     <= 1'b1;
                        bit_cnt_q <= '0;
                    end
                    UTX_STOP: begin
                        if (last_stop) begin
                            state_q <= UTX_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                    default: begin
                        state_q <= UTX_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances cover no parity/1 stop, even/2 stop, odd/1 stop.
module tb_uart_tx;

    logic        clk;
    logic        reset;
    logic [15:0] baud_div;
    logic        wr_en0, wr_en1, wr_en2;
    logic [7:0]  wr_data;
    logic        clr_ovr;

    logic ready0, busy0, done0, ovr0, txd0;
    logic ready1, busy1, done1, ovr1, txd1;
    logic ready2, busy2, done2, ovr2, txd2;

    int checks;
    int failures;

    uart_tx #(.DIV_WIDTH(16), .STOP_BITS(1), .PARITY(0)) dut0 (
        .clk(clk), .reset(reset), .baud_div(baud_div), .wr_en(wr_en0), .wr_data(wr_data),
        .clr_ovr(clr_ovr), .ready(ready0), .busy(busy0), .tx_done(done0), .overrun(ovr0),
        .TxD(txd0)
    );

    uart_tx #(.DIV_WIDTH(16), .STOP_BITS(2), .PARITY(1)) dut1 (
        .clk(clk), .reset(reset), .baud_div(baud_div), .wr_en(wr_en1), .wr_data(wr_data),
        .clr_ovr(clr_ovr), .ready(ready1), .busy(busy1), .tx_done(done1), .overrun(ovr1),
        .TxD(txd1)
    );

    uart_tx #(.DIV_WIDTH(16), .STOP_BITS(1), .PARITY(2)) dut2 (
        .clk(clk), .reset(reset), .baud_div(baud_div), .wr_en(wr_en2), .wr_data(wr_data),
        .clr_ovr(clr_ovr), .ready(ready2), .busy(busy2), .tx_done(done2), .overrun(ovr2),
        .TxD(txd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic txd_of(input int sel);
        case (sel)
            0: return txd0;
            1: return txd1;
            default: return txd2;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            0: return busy0;
            1: return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic done_of(input int sel);
        case (sel)
            0: return done0;
            1: return done1;
            default: return done2;
        endcase
    endfunction

    // Called when cycle c0 of a frame is visible (c=0 is the first start-bit cycle). Walks to
    // the end-of-frame edge; there tx_done must be 1 and the next frame may already begin.
    task automatic frame(input int sel, input logic [7:0] d, input int div, input int par,
                         input int stops, input int c0, input bit next);
        logic [11:0] bits;
        int nb;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        nb = 9;
        if (par != 0) begin
            bits[nb] = (par == 1) ? ^d : ~^d;
            nb++;
        end
        nb = nb + stops;
        for (int c = c0; c < nb * (div + 1); c++) begin
            chk($sformatf("txd dut%0d data=%h c=%0d", sel, d, c), txd_of(sel), bits[c/(div+1)]);
            chk($sformatf("busy dut%0d c=%0d", sel, c), busy_of(sel), 1'b1);
            if (c > 0) chk($sformatf("tx_done dut%0d c=%0d", sel, c), done_of(sel), 1'b0);
            step();
        end
        chk($sformatf("tx_done_end dut%0d data=%h", sel, d), done_of(sel), 1'b1);
        chk($sformatf("busy_end dut%0d data=%h", sel, d), busy_of(sel), next);
        chk($sformatf("txd_end dut%0d data=%h", sel, d), txd_of(sel), !next);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        baud_div = 16'd3;
        wr_en0   = 1'b0;
        wr_en1   = 1'b0;
        wr_en2   = 1'b0;
        wr_data  = 8'h00;
        clr_ovr  = 1'b0;
        step();
        step();
        chk("reset txd", txd0, 1'b1);
        chk("reset ready", ready0, 1'b1);
        chk("reset busy", busy0, 1'b0);
        chk("reset tx_done", done0, 1'b0);
        chk("reset overrun", ovr0, 1'b0);
        reset = 1'b1;
        step();

        // Single frame 0x55, 4-cycle bits, with write latency checks
        wr_en0 = 1'b1; wr_data = 8'h55;
        step();
        wr_en0 = 1'b0;
        chk("lat ready after write", ready0, 1'b0);
        chk("lat txd after write", txd0, 1'b1);
        chk("lat busy after write", busy0, 1'b0);
        step();
        chk("lat ready at start", ready0, 1'b1);
        frame(0, 8'h55, 3, 0, 1, 0, 1'b0);
        step();
        chk("idle tx_done", done0, 1'b0);
        chk("idle busy", busy0, 1'b0);

        // Back-to-back 0xA5 then 0x3C
        wr_en0 = 1'b1; wr_data = 8'hA5;
        step();
        wr_en0 = 1'b0;
        step();
        wr_en0 = 1'b1; wr_data = 8'h3C;
        chk("b2b start bit", txd0, 1'b0);
        step();
        wr_en0 = 1'b0;
        chk("b2b hold full", ready0, 1'b0);
        frame(0, 8'hA5, 3, 0, 1, 1, 1'b1);
        frame(0, 8'h3C, 3, 0, 1, 0, 1'b0);
        step();
        chk("b2b idle ready", ready0, 1'b1);
        chk("b2b no overrun", ovr0, 1'b0);

        // Overrun while hold is full; 0xFF must be dropped
        wr_en0 = 1'b1; wr_data = 8'h0F;
        step();
        wr_en0 = 1'b0;
        step();
        wr_en0 = 1'b1; wr_data = 8'h96;
        step();
        wr_data = 8'hFF;
        step();
        wr_en0 = 1'b0;
        chk("ovr set", ovr0, 1'b1);
        frame(0, 8'h0F, 3, 0, 1, 2, 1'b1);
        frame(0, 8'h96, 3, 0, 1, 0, 1'b0);
        chk("ovr sticky", ovr0, 1'b1);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        chk("ovr cleared", ovr0, 1'b0);

        // Write on the IDLE->START edge is rejected; set beats clear in the same cycle
        wr_en0 = 1'b1; wr_data = 8'h11;
        step();
        wr_data = 8'h22; clr_ovr = 1'b1;
        step();
        wr_en0 = 1'b0; clr_ovr = 1'b0;
        chk("set wins over clr", ovr0, 1'b1);
        frame(0, 8'h11, 3, 0, 1, 0, 1'b0);
        step();
        chk("rejected write not queued", busy0, 1'b0);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        chk("ovr cleared again", ovr0, 1'b0);

        // Even parity with 2 stop bits, then odd parity
        wr_en1 = 1'b1; wr_data = 8'h07;
        step();
        wr_en1 = 1'b0;
        step();
        frame(1, 8'h07, 3, 1, 2, 0, 1'b0);
        step();
        wr_en2 = 1'b1; wr_data = 8'h07;
        step();
        wr_en2 = 1'b0;
        step();
        frame(2, 8'h07, 3, 2, 1, 0, 1'b0);
        step();

        // Reset during the 4th data bit aborts the frame
        wr_en0 = 1'b1; wr_data = 8'h55;
        step();
        wr_en0 = 1'b0;
        step();
        for (int c = 0; c < 17; c++) step();
        chk("pre-reset txd (d3=0)", txd0, 1'b0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("abort txd", txd0, 1'b1);
        chk("abort busy", busy0, 1'b0);
        chk("abort ready", ready0, 1'b1);
        step();
        chk("abort stays idle", busy0, 1'b0);
        wr_en0 = 1'b1; wr_data = 8'h3C;
        step();
        wr_en0 = 1'b0;
        step();
        frame(0, 8'h3C, 3, 0, 1, 0, 1'b0);
        step();

        // Divisor change mid-frame applies only to the next frame
        wr_en0 = 1'b1; wr_data = 8'hA5;
        step();
        wr_data = 8'h5A;
        step();
        step();
        wr_en0 = 1'b0;
        baud_div = 16'd7;
        frame(0, 8'hA5, 3, 0, 1, 1, 1'b1);
        frame(0, 8'h5A, 7, 0, 1, 0, 1'b0);
        step();
        chk("final idle busy", busy0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
